// File: rtl/video_mem_arbiter.sv
// rtl/video_mem_arbiter.sv - framebuffer RAM arbiter with ping-pong line prefetch and 2x scaled scan-out
// Define VIDEO_ARB_BURST_FETCH_EN to fetch every cycle and stall the writer during FETCH.
module video_mem_arbiter #(
   parameter int GB_W     = 160,
   parameter int GB_H     = 144,
   parameter int X_OFFSET = 160,
   parameter int Y_OFFSET = 96
) (
   input  logic        pixel_clock,
   input  logic        reset,
   input  logic [9:0]  pixel_count,
   input  logic [9:0]  line_count,
   input  logic        wr_req,
   input  logic [14:0] wr_addr,
   input  logic [1:0]  wr_data,
   output logic        wr_ack,
   output logic [14:0] mem_addr,
   output logic        mem_we,
   output logic [1:0]  mem_wdata,
   input  logic [1:0]  mem_rdata,
   output logic [1:0]  pixel_out,
   output logic        pixel_valid
);

   localparam logic [9:0]  X_LO     = 10'(X_OFFSET);
   localparam logic [9:0]  X_HI     = 10'(X_OFFSET + 2 * GB_W);
   localparam logic [9:0]  Y_LO     = 10'(Y_OFFSET);
   localparam logic [9:0]  Y_HI     = 10'(Y_OFFSET + 2 * GB_H);
   localparam logic [10:0] F_LO     = 11'(Y_OFFSET);
   localparam logic [10:0] F_HI     = 11'(Y_OFFSET + 2 * GB_H);
   localparam logic [14:0] ROW_W    = 15'(GB_W);
   localparam logic [14:0] FB_WORDS = 15'(GB_W * GB_H);
   localparam logic [7:0]  FX_LAST  = 8'(GB_W - 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [7:0]  fx_q, fx_d;
`ifndef VIDEO_ARB_BURST_FETCH_EN
   logic        phase_q, phase_d;
`endif
   logic [14:0] row_base_q, row_base_d;
   logic        bank_sel_q, bank_sel_d;
   logic        rd_pend_q, rd_pend_d;
   logic [7:0]  rd_idx_q, rd_idx_d;
   logic        rd_bank_q, rd_bank_d;
   logic [14:0] mem_addr_q, mem_addr_d;
   logic        mem_we_q, mem_we_d;
   logic [1:0]  mem_wdata_q, mem_wdata_d;
   logic [1:0]  pixel_out_q, pixel_out_d;
   logic        pixel_valid_q, pixel_valid_d;

   logic [1:0]  bank0_q [GB_W];
   logic [1:0]  bank1_q [GB_W];

   logic [10:0] lc_next;
   logic        trigger;
   logic [7:0]  fetch_row;
   logic        rd_slot, wr_slot;
   logic        in_window;
   logic [7:0]  gx;
   logic        gy_bank;

   // Row r is fetched on the VGA line just before its first displayed line.
   assign lc_next   = {1'b0, line_count} + 11'd1;
   assign trigger   = (pixel_count == 10'd0) && (lc_next >= F_LO) && (lc_next < F_HI)
                      && (lc_next[0] == F_LO[0]);
   assign fetch_row = 8'((lc_next - F_LO) >> 1);

   assign in_window = (pixel_count >= X_LO) && (pixel_count < X_HI)
                      && (line_count >= Y_LO) && (line_count < Y_HI);
   assign gx        = 8'((pixel_count - X_LO) >> 1);
   assign gy_bank   = 1'((line_count - Y_LO) >> 1);

   always_comb begin
      state_d     = state_q;
      fx_d        = fx_q;
`ifndef VIDEO_ARB_BURST_FETCH_EN
      phase_d     = phase_q;
`endif
      row_base_d  = row_base_q;
      bank_sel_d  = bank_sel_q;
      rd_pend_d   = 1'b0;
      rd_idx_d    = rd_idx_q;
      rd_bank_d   = rd_bank_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      rd_slot     = 1'b0;
      wr_slot     = 1'b0;
      wr_ack      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d    = S_FETCH;
               fx_d       = 8'd0;
`ifndef VIDEO_ARB_BURST_FETCH_EN
               phase_d    = 1'b0;
`endif
               row_base_d = {7'd0, fetch_row} * ROW_W;
               bank_sel_d = fetch_row[0];
            end else begin
               wr_slot = 1'b1;
            end
         end
         S_FETCH: begin
`ifdef VIDEO_ARB_BURST_FETCH_EN
            rd_slot = 1'b1;
            fx_d    = fx_q + 8'd1;
            if (fx_q == FX_LAST) begin
               state_d = S_IDLE;
               fx_d    = 8'd0;
            end
`else
            phase_d = ~phase_q;
            rd_slot = ~phase_q;
            wr_slot = phase_q;
            if (phase_q) begin
               fx_d = fx_q + 8'd1;
               if (fx_q == FX_LAST) begin
                  state_d = S_IDLE;
                  fx_d    = 8'd0;
               end
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      // Capture of a read lands one cycle later, tracked by rd_pend/rd_idx/rd_bank.
      if (rd_slot) begin
         mem_addr_d = row_base_q + {7'd0, fx_q};
         rd_pend_d  = 1'b1;
         rd_idx_d   = fx_q;
         rd_bank_d  = bank_sel_q;
      end

      if (wr_slot && wr_req && !reset) begin
         wr_ack = 1'b1;
         if (wr_addr < FB_WORDS) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
         end
      end
   end

   always_comb begin
      pixel_out_d   = 2'd0;
      pixel_valid_d = 1'b0;
      if (in_window) begin
         pixel_valid_d = 1'b1;
         pixel_out_d   = gy_bank ? bank1_q[gx] : bank0_q[gx];
      end
   end

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         fx_q          <= 8'd0;
`ifndef VIDEO_ARB_BURST_FETCH_EN
         phase_q       <= 1'b0;
`endif
         row_base_q    <= 15'd0;
         bank_sel_q    <= 1'b0;
         rd_pend_q     <= 1'b0;
         rd_idx_q      <= 8'd0;
         rd_bank_q     <= 1'b0;
         mem_addr_q    <= 15'd0;
         mem_we_q      <= 1'b0;
         mem_wdata_q   <= 2'd0;
         pixel_out_q   <= 2'd0;
         pixel_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fx_q          <= fx_d;
`ifndef VIDEO_ARB_BURST_FETCH_EN
         phase_q       <= phase_d;
`endif
         row_base_q    <= row_base_d;
         bank_sel_q    <= bank_sel_d;
         rd_pend_q     <= rd_pend_d;
         rd_idx_q      <= rd_idx_d;
         rd_bank_q     <= rd_bank_d;
         mem_addr_q    <= mem_addr_d;
         mem_we_q      <= mem_we_d;
         mem_wdata_q   <= mem_wdata_d;
         pixel_out_q   <= pixel_out_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   // Line buffers keep their contents across reset.
   always_ff @(posedge pixel_clock) begin
      if (!reset && rd_pend_q) begin
         if (rd_bank_q) bank1_q[rd_idx_q] <= mem_rdata;
         else           bank0_q[rd_idx_q] <= mem_rdata;
      end
   end

   assign mem_addr    = mem_addr_q;
   assign mem_we      = mem_we_q;
   assign mem_wdata   = mem_wdata_q;
   assign pixel_out   = pixel_out_q;
   assign pixel_valid = pixel_valid_q;

endmodule
